// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Frames are sent back-to-back while bytes are queued; tx idles high.
module uart_tx_fifo #(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned uart_baud_rate  = 9600,
  parameter int unsigned fifo_depth_log2 = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [fifo_depth_log2:0]   fifo_count
);

  localparam int unsigned DIV    = clock_frequency / uart_baud_rate;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = fifo_depth_log2;
  localparam int unsigned CNT_FW = fifo_depth_log2 + 1;
  localparam int unsigned DEPTH  = 1 << fifo_depth_log2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              push;
  logic              pop;
  logic              cnt_last;

  // Handshake and status decode from registered state.
  assign tx_ready   = (count_q != CNT_FW'(DEPTH));
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign cnt_last   = (cnt_q == CNT_W'(DIV - 1));

  // Next-state: frame sequencing, baud counter, FIFO push/pop and registered line value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    tx_d     = 1'b1;
    pop      = 1'b0;
    push     = tx_valid && tx_ready;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (cnt_last) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          if (count_q != '0) pop     = 1'b1;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts at every bit boundary and holds at zero while idle.
    if ((state_q == S_IDLE) || cnt_last) cnt_d = '0;
    else                                 cnt_d = cnt_q + CNT_W'(1);

    if (pop) begin
      state_d  = S_START;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase

    // Line value for the upcoming cycle, so tx comes straight from a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset drops any queued bytes and any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed frame vectors, corner sequences and randomized traffic
// checked against a frame-level queue model of the transmitter.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_S = 120000;
  localparam int unsigned BAUD  = 9600;
  localparam int DIV_S = CLK_S / BAUD;       // 12 (12.5 truncated)
  localparam int DIV_D = 12000000 / 9600;    // 1250
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data_s = 8'h00;
  logic       tx_valid_s = 1'b0;
  logic       tx_ready_s, tx_s, busy_s;
  logic [2:0] fifo_count_s;
  logic [7:0] tx_data_d = 8'h00;
  logic       tx_valid_d = 1'b0;
  logic       tx_ready_d, tx_d, busy_d;
  logic [2:0] fifo_count_d;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nprint = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;
  vec_t vecs [5];

  uart_tx_fifo #(.clock_frequency(CLK_S), .uart_baud_rate(BAUD), .fifo_depth_log2(2)) u_small (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s), .tx_valid(tx_valid_s),
    .tx_ready(tx_ready_s), .tx(tx_s), .busy(busy_s), .fifo_count(fifo_count_s)
  );

  uart_tx_fifo u_default (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_d), .tx_valid(tx_valid_d),
    .tx_ready(tx_ready_d), .tx(tx_d), .busy(busy_d), .fifo_count(fifo_count_d)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: queue of pending bytes plus position inside the current frame.
  logic [7:0] mq [$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;

  initial forever begin
    bit acc;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      acc = tx_valid_s && (mq.size() < DEPTH);
      if (m_act && m_pos == 10 * DIV_S - 1) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_act = 1'b0;
        end
      end else if (m_act) begin
        m_pos++;
      end else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_pos = 0;
      end
      if (acc) mq.push_back(tx_data_s);
    end
  end

  function automatic logic m_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / DIV_S;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // Every cycle out of reset, the small instance must match the model.
  initial forever begin
    logic       e_tx, e_rdy, e_busy;
    logic [2:0] e_cnt;
    @(negedge clk);
    if (rst_n) begin
      e_tx   = m_tx();
      e_rdy  = (mq.size() < DEPTH);
      e_busy = m_act || (mq.size() > 0);
      e_cnt  = 3'(mq.size());
      checks++;
      if (tx_s !== e_tx || tx_ready_s !== e_rdy || busy_s !== e_busy || fifo_count_s !== e_cnt) begin
        failures++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model t=%0t: tx/ready/busy/count got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                   $time, tx_s, tx_ready_s, busy_s, fifo_count_s, e_tx, e_rdy, e_busy, e_cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input bit sel, input string nm);
    int n;
    n = 0;
    while ((sel ? busy_d : busy_s) && n < 100000) begin
      @(negedge clk);
      n++;
    end
    if (sel ? busy_d : busy_s) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles", nm, n);
    end
  endtask

  // Push one byte from idle and check every bit boundary of the resulting frame.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic [9:0] line, input string nm);
    int dv;
    dv = sel ? DIV_D : DIV_S;
    wait_idle(sel, nm);
    if (sel) begin tx_valid_d = 1'b1; tx_data_d = b; end
    else     begin tx_valid_s = 1'b1; tx_data_s = b; end
    @(negedge clk);
    chk({nm, "_accept_count"}, sel ? fifo_count_d : fifo_count_s, 1);
    chk({nm, "_tx_still_high"}, sel ? tx_d : tx_s, 1);
    if (sel) begin tx_valid_d = 1'b0; tx_data_d = ~b; end
    else     begin tx_valid_s = 1'b0; tx_data_s = ~b; end
    @(negedge clk);
    for (int k = 0; k < 10 * dv; k++) begin
      if (k % dv == 0 || k % dv == dv - 1)
        chk($sformatf("%s_bit%0d_c%0d", nm, k / dv, k), sel ? tx_d : tx_s, line[k / dv]);
      if (k == 10 * dv - 1) chk({nm, "_busy_in_stop"}, sel ? busy_d : busy_s, 1);
      @(negedge clk);
    end
    chk({nm, "_tx_idle"}, sel ? tx_d : tx_s, 1);
    chk({nm, "_busy_low"}, sel ? busy_d : busy_s, 0);
  endtask

  initial begin
    int e0;
    int n;
    int lim;

    vecs[0] = '{8'h00, 10'h200};
    vecs[1] = '{8'hFF, 10'h3FE};
    vecs[2] = '{8'hA3, 10'h346};
    vecs[3] = '{8'h01, 10'h202};
    vecs[4] = '{8'hC6, 10'h38C};

    // Reset state on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_s", tx_s, 1);
    chk("rst_ready_s", tx_ready_s, 1);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_count_s", fifo_count_s, 0);
    chk("rst_tx_d", tx_d, 1);
    chk("rst_ready_d", tx_ready_d, 1);
    chk("rst_busy_d", busy_d, 0);
    chk("rst_count_d", fifo_count_d, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x55 at the default bit period of 1250 cycles.
    send_frame(1'b1, 8'h55, 10'h2AA, "def_55");

    // Table-driven frames at the short bit period.
    for (int i = 0; i < 5; i++)
      send_frame(1'b0, vecs[i].data, vecs[i].line, $sformatf("vec%0d_%0h", i, vecs[i].data));

    // Burst 0x01..0x06 on consecutive cycles.
    wait_idle(1'b0, "burst");
    e0 = cyc;
    for (int v = 1; v <= 5; v++) begin
      if (v == 3) begin
        chk("burst_first_popped_count", fifo_count_s, 1);
        chk("burst_first_tx_low", tx_s, 0);
      end
      chk($sformatf("burst_ready_%0d", v), tx_ready_s, 1);
      tx_valid_s = 1'b1;
      tx_data_s  = 8'(v);
      @(negedge clk);
    end
    chk("burst_count_full", fifo_count_s, 4);
    chk("burst_ready_low", tx_ready_s, 0);
    tx_data_s = 8'h06;
    n = 0;
    while (!tx_ready_s && n < 20 * DIV_S) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid_s = 1'b0;
    chk("burst_06_accept_edge", cyc - e0, 3 + 10 * DIV_S);
    chk("burst_count_after_06", fifo_count_s, 4);
    wait_idle(1'b0, "burst_drain");
    chk("burst_total_cycles", cyc - e0, 2 + 60 * DIV_S);

    // Push coinciding with the stop-bit pop while two bytes are queued.
    wait_idle(1'b0, "pp");
    e0 = cyc;
    tx_valid_s = 1'b1; tx_data_s = 8'h5A; @(negedge clk);
    tx_data_s = 8'hC3; @(negedge clk);
    tx_data_s = 8'h0F; @(negedge clk);
    tx_valid_s = 1'b0;
    chk("pp_count_two", fifo_count_s, 2);
    while (cyc < e0 + 1 + 10 * DIV_S) @(negedge clk);
    chk("pp_count_before", fifo_count_s, 2);
    chk("pp_stop_high", tx_s, 1);
    tx_valid_s = 1'b1; tx_data_s = 8'h96;
    @(negedge clk);
    tx_valid_s = 1'b0;
    chk("pp_count_after", fifo_count_s, 2);
    chk("pp_next_start", tx_s, 0);
    wait_idle(1'b0, "pp_drain");

    // Asynchronous reset in the middle of a frame with a byte queued.
    e0 = cyc;
    tx_valid_s = 1'b1; tx_data_s = 8'hA3; @(negedge clk);
    tx_data_s = 8'h11; @(negedge clk);
    tx_valid_s = 1'b0;
    while (cyc < e0 + 2 + 4 * DIV_S + 3) @(negedge clk);
    chk("midrst_pre_tx", tx_s, 0);
    chk("midrst_pre_count", fifo_count_s, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx_s, 1);
    chk("midrst_ready", tx_ready_s, 1);
    chk("midrst_busy", busy_s, 0);
    chk("midrst_count", fifo_count_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b0, 8'h3C, 10'h278, "after_rst_3c");
    repeat (3 * DIV_S) @(negedge clk);
    chk("after_rst_quiet_tx", tx_s, 1);
    chk("after_rst_quiet_busy", busy_s, 0);

    // Randomized traffic: sparse then heavy enough to keep the FIFO full.
    for (int i = 0; i < 4000; i++) begin
      lim = (i < 2000) ? 40 : 3;
      tx_valid_s = ($urandom_range(0, lim) == 0);
      tx_data_s  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid_s = 1'b0;
    wait_idle(1'b0, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
